simt_mask_ctrl: RTL and testbench

- Divergence controller that sits directly upstream of the predicate mask stack (pstack) in the scheduler.
- Accepts decoded IF/ELSE/ENDIF ops with per-core branch predicates and sequences the stack's push/pop handshakes.
- Publishes the resulting per-core active mask to the core-enable logic.
- Also performs stack initialisation after reset and detects nesting overflow and underflow.

---
 rtl/simt_mask_ctrl_pkg.sv | 25 ++
 rtl/simt_mask_ctrl_if.sv | 26 ++
 rtl/simt_mask_ctrl.sv | 152 +++++++++++++++
 tb/tb_simt_mask_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/simt_mask_ctrl_pkg.sv
// rtl/simt_mask_ctrl_pkg.sv - shared constants, op codes and FSM encoding for the divergence controller
package simt_mask_ctrl_pkg;

  localparam int N_CORES     = 4;
  localparam int STACK_DEPTH = 3;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_IF    = 2'b01,
    OP_ELSE  = 2'b10,
    OP_ENDIF = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_INIT_W,
    ST_IDLE,
    ST_IF_W,
    ST_ELSE_POP,
    ST_ELSE_W,
    ST_ELSE_PUSH,
    ST_POP_W
  } state_e;

endpackage

// File: rtl/simt_mask_ctrl_if.sv
// rtl/simt_mask_ctrl_if.sv - op request and predicate-stack handshake bundle
interface simt_mask_ctrl_if #(
  parameter int N_CORES = simt_mask_ctrl_pkg::N_CORES
) ();

  logic               op_valid;
  logic               op_ready;
  logic [1:0]         op_code;
  logic [N_CORES-1:0] pred;
  logic               stk_push;
  logic               stk_pop;
  logic [N_CORES-1:0] stk_d;
  logic [N_CORES-1:0] stk_q;

  // master is the scheduler side together with the stack; slave is the controller
  modport master (
    output op_valid, op_code, pred, stk_q,
    input  op_ready, stk_push, stk_pop, stk_d
  );

  modport slave (
    input  op_valid, op_code, pred, stk_q,
    output op_ready, stk_push, stk_pop, stk_d
  );

endinterface

// File: rtl/simt_mask_ctrl.sv
// rtl/simt_mask_ctrl.sv - IF/ELSE/ENDIF divergence controller sequencing the predicate mask stack
module simt_mask_ctrl #(
  parameter int N_CORES     = simt_mask_ctrl_pkg::N_CORES,
  parameter int STACK_DEPTH = simt_mask_ctrl_pkg::STACK_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  simt_mask_ctrl_if.slave        bus,
  output logic [N_CORES-1:0]     active_mask,
  output logic [STACK_DEPTH-1:0] depth,
  output logic                   ovf,
  output logic                   udf
);
  import simt_mask_ctrl_pkg::*;

  // Deepest legal nesting is the all-ones pointer value, base level included.
  localparam logic [STACK_DEPTH-1:0] DEPTH_MAX = '1;
  localparam logic [STACK_DEPTH-1:0] DEPTH_ONE = STACK_DEPTH'(1);

  state_e                 state_q, state_d;
  logic [N_CORES-1:0]     mask_q, mask_d;
  logic [STACK_DEPTH-1:0] depth_q, depth_d;
  logic                   ovf_q, ovf_d;
  logic                   udf_q, udf_d;
  logic [N_CORES-1:0]     then_q, then_d;
  logic [N_CORES-1:0]     parent_q, parent_d;

  logic                   op_ready_c;
  logic                   push_c;
  logic                   pop_c;
  logic [N_CORES-1:0]     stk_d_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_INIT;
      mask_q   <= '0;
      depth_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      then_q   <= '0;
      parent_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      depth_q  <= depth_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      then_q   <= then_d;
      parent_q <= parent_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    depth_d    = depth_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    then_d     = then_q;
    parent_d   = parent_q;
    op_ready_c = 1'b0;
    push_c     = 1'b0;
    pop_c      = 1'b0;
    stk_d_c    = '0;

    case (state_q)
      ST_INIT: begin
        push_c  = 1'b1;
        stk_d_c = '1;
        depth_d = DEPTH_ONE;
        state_d = ST_INIT_W;
      end
      ST_INIT_W: begin
        mask_d  = bus.stk_q;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        op_ready_c = 1'b1;
        if (bus.op_valid) begin
          case (op_e'(bus.op_code))
            OP_IF: begin
              if (depth_q != DEPTH_MAX) begin
                push_c  = 1'b1;
                stk_d_c = mask_q & bus.pred;
                depth_d = depth_q + DEPTH_ONE;
                state_d = ST_IF_W;
              end else begin
                ovf_d = 1'b1;
              end
            end
            OP_ELSE: begin
              // Depth is left untouched: the pop and the re-push cancel out.
              if (depth_q > DEPTH_ONE) begin
                then_d  = mask_q;
                pop_c   = 1'b1;
                state_d = ST_ELSE_W;
              end else begin
                udf_d = 1'b1;
              end
            end
            OP_ENDIF: begin
              if (depth_q > DEPTH_ONE) begin
                pop_c   = 1'b1;
                depth_d = depth_q - DEPTH_ONE;
                state_d = ST_POP_W;
              end else begin
                udf_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_IF_W, ST_POP_W: begin
        mask_d  = bus.stk_q;
        state_d = ST_IDLE;
      end
      ST_ELSE_POP: begin
        pop_c   = 1'b1;
        state_d = ST_ELSE_W;
      end
      ST_ELSE_W: begin
        parent_d = bus.stk_q;
        state_d  = ST_ELSE_PUSH;
      end
      ST_ELSE_PUSH: begin
        push_c  = 1'b1;
        stk_d_c = parent_q & ~then_q;
        state_d = ST_IF_W;
      end
      default: state_d = ST_INIT;
    endcase

    // Nothing reaches the stack or the scheduler while reset is held.
    if (reset) begin
      op_ready_c = 1'b0;
      push_c     = 1'b0;
      pop_c      = 1'b0;
    end
  end

  assign bus.op_ready = op_ready_c;
  assign bus.stk_push = push_c;
  assign bus.stk_pop  = pop_c;
  assign bus.stk_d    = stk_d_c;

  assign active_mask  = mask_q;
  assign depth        = depth_q;
  assign ovf          = ovf_q;
  assign udf          = udf_q;

endmodule

// File: tb/tb_simt_mask_ctrl.sv
// tb/tb_simt_mask_ctrl.sv - scoreboard bench for simt_mask_ctrl with a behavioural predicate stack
module tb_simt_mask_ctrl;
  import simt_mask_ctrl_pkg::*;

  localparam int NC = 4;
  localparam int SD = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NC-1:0] active_mask;
  logic [SD-1:0] depth;
  logic          ovf;
  logic          udf;

  always #5 clk = ~clk;

  simt_mask_ctrl_if #(.N_CORES(NC)) bus ();

  simt_mask_ctrl #(.N_CORES(NC), .STACK_DEPTH(SD)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .active_mask(active_mask),
    .depth      (depth),
    .ovf        (ovf),
    .udf        (udf)
  );

  logic [NC-1:0] stk_mem [0:(1<<SD)-1];
  logic [SD-1:0] sp;
  logic [NC-1:0] stk_q_r;

  always @(posedge clk) begin
    if (reset) begin
      sp         <= '0;
      stk_q_r    <= '0;
      stk_mem[0] <= '0;
    end else if (bus.stk_push) begin
      sp                <= sp + 1'b1;
      stk_mem[sp + 1'b1] <= bus.stk_d;
      stk_q_r           <= bus.stk_d;
    end else if (bus.stk_pop) begin
      sp      <= sp - 1'b1;
      stk_q_r <= stk_mem[sp - 1'b1];
    end
  end

  assign bus.stk_q = stk_q_r;

  typedef struct {
    string         name;
    logic [NC-1:0] mask;
    logic [SD-1:0] depth;
    logic          ovf;
    logic          udf;
    int            npush;
    int            npop;
    logic [NC-1:0] pd;
    int            lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  function automatic void expect_op(input string name, input logic [NC-1:0] mask, input logic [SD-1:0] dep,
                                    input logic o, input logic u, input int np, input int npp,
                                    input logic [NC-1:0] pd, input int lat);
    exp_t e;
    e.name = name; e.mask = mask; e.depth = dep; e.ovf = o; e.udf = u;
    e.npush = np; e.npop = npp; e.pd = pd; e.lat = lat;
    exp_q.push_back(e);
  endfunction

  // Monitor: tracks each accepted op until op_ready returns, then scores it.
  initial begin
    bit            busy;
    int            lat, npush, npop;
    logic [NC-1:0] pd_seen;
    exp_t          e;
    busy = 1'b0; lat = 0; npush = 0; npop = 0; pd_seen = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 1'b1; lat = 0; npush = 0; npop = 0;
      end else begin
        if (bus.stk_push && bus.stk_pop) chk("push_pop_exclusive", 1, 0);
        if (busy) begin
          lat++;
          if (bus.op_ready) begin
            busy = 1'b0;
            if (exp_q.size() == 0) begin
              chk("unexpected_completion", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk({e.name, ".mask"},  active_mask, e.mask);
              chk({e.name, ".depth"}, depth, e.depth);
              chk({e.name, ".ovf"},   ovf, e.ovf);
              chk({e.name, ".udf"},   udf, e.udf);
              chk({e.name, ".npush"}, npush, e.npush);
              chk({e.name, ".npop"},  npop, e.npop);
              chk({e.name, ".lat"},   lat, e.lat);
              if (e.npush > 0) chk({e.name, ".stk_d"}, pd_seen, e.pd);
            end
          end else begin
            if (bus.stk_push) begin npush++; pd_seen = bus.stk_d; end
            if (bus.stk_pop) npop++;
          end
        end
        if (!busy) begin
          if (bus.op_valid && bus.op_ready) begin
            busy = 1'b1; lat = 0; npush = 0; npop = 0;
            if (bus.stk_push) begin npush++; pd_seen = bus.stk_d; end
            if (bus.stk_pop) npop++;
          end else if (bus.stk_push || bus.stk_pop) begin
            chk("idle_strobe", 1, 0);
          end
        end
      end
    end
  end

  task automatic issue(input logic [1:0] code, input logic [NC-1:0] pred);
    int n;
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.pred     = pred;
    n = 0;
    @(negedge clk);
    while (!bus.op_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.op_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.op_code  = OP_NOP;
  endtask

  task automatic op(input string name, input logic [1:0] code, input logic [NC-1:0] pred,
                    input logic [NC-1:0] mask, input logic [SD-1:0] dep, input logic o, input logic u,
                    input int np, input int npp, input logic [NC-1:0] pd, input int lat);
    expect_op(name, mask, dep, o, u, np, npp, pd, lat);
    issue(code, pred);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".mask"},     active_mask, 0);
    chk({tag, ".depth"},    depth, 0);
    chk({tag, ".ovf"},      ovf, 0);
    chk({tag, ".udf"},      udf, 0);
    chk({tag, ".op_ready"}, bus.op_ready, 0);
    chk({tag, ".push"},     bus.stk_push, 0);
    chk({tag, ".pop"},      bus.stk_pop, 0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    expect_op("init", 4'b1111, 2'd1, 1'b0, 1'b0, 1, 0, 4'b1111, 3);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    bus.op_valid = 1'b0;
    bus.op_code  = OP_NOP;
    bus.pred     = '0;
    reset        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_state("rst0");
    release_reset();

    op("if_0101",   OP_IF,    4'b0101, 4'b0101, 2'd2, 0, 0, 1, 0, 4'b0101, 2);
    op("else_1",    OP_ELSE,  4'b0000, 4'b1010, 2'd2, 0, 0, 1, 1, 4'b1010, 4);
    op("endif_1",   OP_ENDIF, 4'b0000, 4'b1111, 2'd1, 0, 0, 0, 1, 4'b0000, 2);
    op("if_0011",   OP_IF,    4'b0011, 4'b0011, 2'd2, 0, 0, 1, 0, 4'b0011, 2);
    op("if_0110",   OP_IF,    4'b0110, 4'b0010, 2'd3, 0, 0, 1, 0, 4'b0010, 2);
    op("else_nest", OP_ELSE,  4'b1111, 4'b0001, 2'd3, 0, 0, 1, 1, 4'b0001, 4);
    op("endif_n1",  OP_ENDIF, 4'b0000, 4'b0011, 2'd2, 0, 0, 0, 1, 4'b0000, 2);
    op("endif_n2",  OP_ENDIF, 4'b0000, 4'b1111, 2'd1, 0, 0, 0, 1, 4'b0000, 2);
    op("if_1110",   OP_IF,    4'b1110, 4'b1110, 2'd2, 0, 0, 1, 0, 4'b1110, 2);
    op("if_1100",   OP_IF,    4'b1100, 4'b1100, 2'd3, 0, 0, 1, 0, 4'b1100, 2);
    op("if_ovf",    OP_IF,    4'b1000, 4'b1100, 2'd3, 1, 0, 0, 0, 4'b0000, 1);
    op("nop_max",   OP_NOP,   4'b1111, 4'b1100, 2'd3, 1, 0, 0, 0, 4'b0000, 1);
    op("endif_o1",  OP_ENDIF, 4'b0000, 4'b1110, 2'd2, 1, 0, 0, 1, 4'b0000, 2);
    op("endif_o2",  OP_ENDIF, 4'b0000, 4'b1111, 2'd1, 1, 0, 0, 1, 4'b0000, 2);
    op("endif_udf", OP_ENDIF, 4'b0000, 4'b1111, 2'd1, 1, 1, 0, 0, 4'b0000, 1);
    op("else_udf",  OP_ELSE,  4'b0000, 4'b1111, 2'd1, 1, 1, 0, 0, 4'b0000, 1);
    op("nop_base",  OP_NOP,   4'b1111, 4'b1111, 2'd1, 1, 1, 0, 0, 4'b0000, 1);
    op("if_1001",   OP_IF,    4'b1001, 4'b1001, 2'd2, 1, 1, 1, 0, 4'b1001, 2);
    op("else_r1",   OP_ELSE,  4'b0000, 4'b0110, 2'd2, 1, 1, 1, 1, 4'b0110, 4);
    op("else_r2",   OP_ELSE,  4'b0000, 4'b1001, 2'd2, 1, 1, 1, 1, 4'b1001, 4);
    op("endif_r",   OP_ENDIF, 4'b0000, 4'b1111, 2'd1, 1, 1, 0, 1, 4'b0000, 2);
    op("if_0101b",  OP_IF,    4'b0101, 4'b0101, 2'd2, 1, 1, 1, 0, 4'b0101, 2);

    // ELSE accepted, then reset lands while the controller waits on the pop.
    issue(OP_ELSE, 4'b0000);
    reset = 1'b1;
    @(negedge clk);
    chk("abort.push", bus.stk_push, 0);
    chk("abort.pop",  bus.stk_pop, 0);
    @(negedge clk);
    chk_reset_state("rst1");
    release_reset();

    op("if_0000",   OP_IF,    4'b0000, 4'b0000, 2'd2, 0, 0, 1, 0, 4'b0000, 2);
    op("endif_z",   OP_ENDIF, 4'b0000, 4'b1111, 2'd1, 0, 0, 0, 1, 4'b0000, 2);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
